// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: boundary modes and default widths.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_PRE_W = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: emits a tick on the enabled cycle where the
// internal count matches prescale, then restarts the period from zero.
module tick_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    // prescale is compared only here, so a mid-period change simply moves
    // the match point of the current period.
    assign tick = en && (pre_cnt == prescale);

    // Period counter; clr discards any partial period (used on load).
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (tick) pre_cnt <= '0;
            else      pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parameterized up/down counter with prescaled stepping, runtime terminal
// value, wrap or saturate boundary handling, tc pulse and sticky ovf flag.
import counter_pkg::*;

module param_updown_counter #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRE_W    = DEF_PRE_W,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic [PRE_W-1:0] prescale,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam bit SAT = (SATURATE == MODE_SAT);

    logic             tick;
    logic             bnd;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] load_clamped;

    tick_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );

    // Loaded values never exceed the current terminal value.
    assign load_clamped = (load_val > max_val) ? max_val : load_val;

    // Next count for a tick; bnd flags a boundary event. A count left above a
    // freshly lowered max_val is treated as being at the boundary when going up.
    always_comb begin
        nxt = count;
        bnd = 1'b0;
        if (up) begin
            if (count < max_val) begin
                nxt = count + WIDTH'(1);
            end else begin
                bnd = 1'b1;
                nxt = SAT ? max_val : '0;
            end
        end else begin
            if (count != '0) begin
                nxt = count - WIDTH'(1);
            end else begin
                bnd = 1'b1;
                nxt = SAT ? '0 : max_val;
            end
        end
    end

    // Counter state: reset > load > tick step; ovf set beats ovf_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
            ovf   <= ovf & ~ovf_clr;
        end else begin
            tc  <= tick & bnd;
            ovf <= (tick & bnd) | (ovf & ~ovf_clr);
            if (tick) count <= nxt;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: one wrap and one saturate instance driven in parallel by a
// vector table, plus sequences for free-running wrap and prescaler timing.
module tb_param_updown_counter;

    localparam int W = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset, en, up, load, ovf_clr;
    logic [W-1:0] load_val, max_val;
    logic [P-1:0] prescale;
    logic [W-1:0] count_w, count_s;
    logic         tc_w, tc_s, ovf_w, ovf_s;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(W), .PRE_W(P), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val), .prescale(prescale),
        .ovf_clr(ovf_clr), .count(count_w), .tc(tc_w), .ovf(ovf_w)
    );

    param_updown_counter #(.WIDTH(W), .PRE_W(P), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val), .prescale(prescale),
        .ovf_clr(ovf_clr), .count(count_s), .tc(tc_s), .ovf(ovf_s)
    );

    typedef struct {
        logic         r, e, u, ld;
        logic [W-1:0] lv, mv;
        logic [P-1:0] ps;
        logic         oc;
        int           cw, tw, ow;
        int           cs, ts, os;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic ld,
                         input logic [W-1:0] lv, input logic [W-1:0] mv,
                         input logic [P-1:0] ps, input logic oc);
        reset = r; en = e; up = u; load = ld;
        load_val = lv; max_val = mv; prescale = ps; ovf_clr = oc;
    endtask

    initial begin
        int exp_c, en_edges;
        logic e, r;

        //          r  e  u  ld  lv   mv  ps oc   cw tw ow   cs ts os
        vecs[0]  = '{1, 1, 1, 1,   5,   9, 0, 0,   0, 0, 0,   0, 0, 0};
        vecs[1]  = '{0, 1, 1, 0,   0,   9, 0, 0,   1, 0, 0,   1, 0, 0};
        vecs[2]  = '{0, 1, 1, 1, 255, 200, 0, 0, 200, 0, 0, 200, 0, 0};
        vecs[3]  = '{0, 1, 1, 0,   0, 200, 0, 0,   0, 1, 1, 200, 1, 1};
        vecs[4]  = '{0, 1, 1, 0,   0, 200, 0, 0,   1, 0, 1, 200, 1, 1};
        vecs[5]  = '{0, 1, 0, 0,   0, 200, 0, 0,   0, 0, 1, 199, 0, 1};
        vecs[6]  = '{0, 1, 0, 0,   0,  15, 0, 1,  15, 1, 1, 198, 0, 0};
        vecs[7]  = '{0, 0, 0, 0,   0,  15, 0, 0,  15, 0, 1, 198, 0, 0};
        vecs[8]  = '{0, 1, 0, 1,   5,  15, 0, 0,   5, 0, 1,   5, 0, 0};
        vecs[9]  = '{0, 0, 0, 0,   0,  15, 0, 1,   5, 0, 0,   5, 0, 0};
        vecs[10] = '{0, 0, 1, 1,  50, 255, 0, 0,  50, 0, 0,  50, 0, 0};
        vecs[11] = '{0, 1, 1, 0,   0,  20, 0, 0,   0, 1, 1,  20, 1, 1};
        vecs[12] = '{0, 1, 0, 0,   0,  20, 0, 0,  20, 1, 1,  19, 0, 1};
        vecs[13] = '{0, 1, 1, 1,   3,   2, 0, 0,   2, 0, 1,   2, 0, 1};
        vecs[14] = '{0, 1, 1, 0,   0,   2, 0, 0,   0, 1, 1,   2, 1, 1};

        drive(1, 0, 1, 0, 0, 9, 0, 0);
        step();
        chk("reset count_w", int'(count_w), 0);
        chk("reset tc_w", int'(tc_w), 0);
        chk("reset ovf_w", int'(ovf_w), 0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].ld,
                  vecs[i].lv, vecs[i].mv, vecs[i].ps, vecs[i].oc);
            step();
            chk($sformatf("v%0d count_w", i), int'(count_w), vecs[i].cw);
            chk($sformatf("v%0d tc_w", i),    int'(tc_w),    vecs[i].tw);
            chk($sformatf("v%0d ovf_w", i),   int'(ovf_w),   vecs[i].ow);
            chk($sformatf("v%0d count_s", i), int'(count_s), vecs[i].cs);
            chk($sformatf("v%0d tc_s", i),    int'(tc_s),    vecs[i].ts);
            chk($sformatf("v%0d ovf_s", i),   int'(ovf_s),   vecs[i].os);
        end

        // Free-running up count to max_val=9 from reset.
        drive(1, 1, 1, 0, 0, 9, 0, 0);
        step();
        drive(0, 1, 1, 0, 0, 9, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("run%0d count_w", k), int'(count_w), k % 10);
            chk($sformatf("run%0d tc_w", k),    int'(tc_w),    (k == 10) ? 1 : 0);
            chk($sformatf("run%0d ovf_w", k),   int'(ovf_w),   (k >= 10) ? 1 : 0);
            chk($sformatf("run%0d count_s", k), int'(count_s), (k < 9) ? k : 9);
            chk($sformatf("run%0d tc_s", k),    int'(tc_s),    (k >= 10) ? 1 : 0);
        end

        // prescale=3: step on every 4th enabled edge; en gap and mid-period reset.
        drive(1, 1, 1, 0, 0, 255, 3, 0);
        step();
        exp_c = 0;
        en_edges = 0;
        for (int k = 1; k <= 22; k++) begin
            e = !(k == 10 || k == 11);
            r = (k == 14);
            drive(r, e, 1, 0, 0, 255, 3, 0);
            step();
            if (r) begin
                exp_c = 0;
                en_edges = 0;
            end else if (e) begin
                en_edges++;
                if (en_edges % 4 == 0) exp_c++;
            end
            chk($sformatf("pre%0d count_w", k), int'(count_w), exp_c);
            chk($sformatf("pre%0d count_s", k), int'(count_s), exp_c);
            chk($sformatf("pre%0d tc_w", k),    int'(tc_w),    0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
